// File: rtl/periph_bus_router.sv
// Address router from a single-outstanding master onto NUM_PERIPH peripheral windows.
// Request path is combinational; the response is registered one cycle after the peripheral response, and the router blocks while a transaction is open.
module periph_bus_router #(
  parameter int unsigned                  NUM_PERIPH       = 3,
  parameter int unsigned                  ADDR_W           = 32,
  parameter int unsigned                  DATA_W           = 32,
  parameter logic [NUM_PERIPH-1:0]        PERIPH_SUPPORTED = '1,
  parameter logic [NUM_PERIPH*ADDR_W-1:0] PERIPH_BASE      = '0,
  parameter logic [NUM_PERIPH*ADDR_W-1:0] PERIPH_RANGE     = '0,
  parameter int unsigned                  TIMEOUT_CYCLES   = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ADDR_W-1:0]            req_addr_i,
  input  logic                         req_we_i,
  input  logic [DATA_W/8-1:0]          req_be_i,
  input  logic [DATA_W-1:0]            req_wdata_i,
  output logic                         rsp_valid_o,
  output logic [DATA_W-1:0]            rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic [NUM_PERIPH-1:0]        p_req_valid_o,
  input  logic [NUM_PERIPH-1:0]        p_req_ready_i,
  output logic [ADDR_W-1:0]            p_req_addr_o,
  output logic                         p_req_we_o,
  output logic [DATA_W/8-1:0]          p_req_be_o,
  output logic [DATA_W-1:0]            p_req_wdata_o,
  input  logic [NUM_PERIPH-1:0]        p_rsp_valid_i,
  input  logic [NUM_PERIPH*DATA_W-1:0] p_rsp_rdata_i,
  input  logic [NUM_PERIPH-1:0]        p_rsp_err_i,
  output logic [15:0]                  timeout_cnt_o
);

  localparam int unsigned IDX_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  // The timer only ever needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_PERIPH-1:0] win_hit;
  logic [ADDR_W-1:0]     win_off [NUM_PERIPH];
  logic [DATA_W-1:0]     p_rdata [NUM_PERIPH];
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic [IDX_W-1:0]      sel_q;
  logic                  we_q;
  logic [TMR_W-1:0]      timer_q;
  logic                  accept;
  logic                  rsp_hit;
  logic                  tmo_fire;

  for (genvar i = 0; i < NUM_PERIPH; i++) begin : g_win
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_range;
    assign w_base     = PERIPH_BASE[i*ADDR_W +: ADDR_W];
    assign w_range    = PERIPH_RANGE[i*ADDR_W +: ADDR_W];
    assign win_off[i] = req_addr_i - w_base;
    assign win_hit[i] = PERIPH_SUPPORTED[i] && (req_addr_i >= w_base) && (win_off[i] <= w_range);
    assign p_rdata[i] = p_rsp_rdata_i[i*DATA_W +: DATA_W];
  end

  // Lowest matching index wins on overlapping windows.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(NUM_PERIPH); i++) begin
      if (win_hit[i] && !hit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign p_req_addr_o  = win_off[hit_idx];
  assign p_req_we_o    = req_we_i;
  assign p_req_be_o    = req_be_i;
  assign p_req_wdata_o = req_wdata_i;

  assign accept   = req_valid_i && req_ready_o;
  assign rsp_hit  = (state_q == S_WAIT) && p_rsp_valid_i[sel_q];
  assign tmo_fire = TMO_EN && (state_q == S_WAIT) && !p_rsp_valid_i[sel_q] && (timer_q == TMR_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = hit ? S_WAIT : S_ERR;
      S_WAIT:  if (rsp_hit || tmo_fire) state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request handshake is held off entirely while reset is asserted.
  always_comb begin
    req_ready_o   = 1'b0;
    p_req_valid_o = '0;
    if (rst_ni && (state_q == S_IDLE) && req_valid_i) begin
      if (hit) begin
        p_req_valid_o[hit_idx] = 1'b1;
        req_ready_o            = p_req_ready_i[hit_idx];
      end else begin
        req_ready_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q         <= '0;
      we_q          <= 1'b0;
      timer_q       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_err_o     <= 1'b0;
      rsp_rdata_o   <= '0;
      timeout_cnt_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      if (accept) begin
        timer_q <= '0;
        if (hit) begin
          sel_q <= hit_idx;
          we_q  <= req_we_i;
        end else begin
          // The miss response is raised on entry so it shows during the ERR state.
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b1;
        end
      end
      if (rsp_hit) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= p_rsp_err_i[sel_q];
        rsp_rdata_o <= we_q ? '0 : p_rdata[sel_q];
      end else if (tmo_fire) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= 1'b1;
        if (timeout_cnt_o != 16'hFFFF) begin
          timeout_cnt_o <= timeout_cnt_o + 16'd1;
        end
      end else if (TMO_EN && (state_q == S_WAIT)) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  a_p_req_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(p_req_valid_o));
  a_busy_no_ready: assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q != S_IDLE) |-> !req_ready_o);

endmodule

// File: tb/tb_periph_bus_router.sv
// Randomised scoreboard bench for periph_bus_router: four windows (one disabled, two overlapping), timeout of 8.
module tb_periph_bus_router;

  localparam int NP = 4;
  localparam int T  = 8;
  localparam logic [NP-1:0] SUP = 4'b0111;
  localparam logic [31:0] BASES  [NP] = '{32'h3000_0000, 32'h1000_0000, 32'h3000_0080, 32'h4000_0000};
  localparam logic [31:0] RANGES [NP] = '{32'h0000_00FF, 32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_00FF};

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
    logic [15:0] tcnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic             req_we;
  logic [3:0]       req_be;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [NP-1:0]    p_req_valid;
  logic [NP-1:0]    p_req_ready;
  logic [31:0]      p_req_addr;
  logic             p_req_we;
  logic [3:0]       p_req_be;
  logic [31:0]      p_req_wdata;
  logic [NP-1:0]    p_rsp_valid;
  logic [NP*32-1:0] p_rsp_rdata;
  logic [NP-1:0]    p_rsp_err;
  logic [15:0]      timeout_cnt;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   hold_until = 0;
  int   next_free = 0;
  int   last_a = 0;
  int   r_cycle = -1;
  int   r_idx = 0;
  logic [31:0] r_data = '0;
  logic        r_err = 1'b0;
  logic [15:0] exp_tcnt = '0;
  exp_t exp_q[$];

  periph_bus_router #(
    .NUM_PERIPH      (NP),
    .ADDR_W          (32),
    .DATA_W          (32),
    .PERIPH_SUPPORTED(SUP),
    .PERIPH_BASE     ({BASES[3], BASES[2], BASES[1], BASES[0]}),
    .PERIPH_RANGE    ({RANGES[3], RANGES[2], RANGES[1], RANGES[0]}),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_we_i     (req_we),
    .req_be_i     (req_be),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .p_req_valid_o(p_req_valid),
    .p_req_ready_i(p_req_ready),
    .p_req_addr_o (p_req_addr),
    .p_req_we_o   (p_req_we),
    .p_req_be_o   (p_req_be),
    .p_req_wdata_o(p_req_wdata),
    .p_rsp_valid_i(p_rsp_valid),
    .p_rsp_rdata_i(p_rsp_rdata),
    .p_rsp_err_i  (p_rsp_err),
    .timeout_cnt_o(timeout_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Window lookup done in 64-bit so the upper bound can never wrap.
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NP; i++) begin
      if (SUP[i] && (64'(a) >= 64'(BASES[i])) && (64'(a) <= 64'(BASES[i]) + 64'(RANGES[i])))
        return i;
    end
    return -1;
  endfunction

  // Peripheral side: random ready, random noise on unselected peripherals, scheduled response.
  always begin
    @(posedge clk);
    #1;
    p_req_ready = 4'($urandom);
    p_rsp_valid = 4'($urandom) & 4'($urandom) & ~(4'b1 << r_idx);
    p_rsp_err   = 4'($urandom);
    for (int i = 0; i < NP; i++) p_rsp_rdata[i*32 +: 32] = $urandom;
    if (cyc == r_cycle) begin
      p_rsp_valid[r_idx]          = 1'b1;
      p_rsp_rdata[r_idx*32 +: 32] = r_data;
      p_rsp_err[r_idx]            = r_err;
    end
  end

  always @(negedge clk) begin
    exp_t it;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d, required none", cyc);
      end else begin
        it = exp_q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(it.due));
        check("rsp_err", 64'(rsp_err), 64'(it.err));
        check("rsp_rdata", 64'(rsp_rdata), 64'(it.rdata));
        check("timeout_cnt", 64'(timeout_cnt), 64'(it.tcnt));
      end
    end
  end

  // lat: peripheral response delay after accept in cycles; 0 means it never responds.
  task automatic do_txn(input logic [31:0] addr, input logic we, input int lat,
                        input logic [31:0] data, input logic err);
    int   idx;
    int   a;
    bit   acc;
    exp_t it;
    while (cyc < hold_until) begin
      @(posedge clk);
      #1;
    end
    idx       = decode(addr);
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_be    = 4'($urandom);
    req_wdata = $urandom;
    acc       = 1'b0;
    a         = 0;
    for (int w = 0; w < 80 && !acc; w++) begin
      @(negedge clk);
      if (cyc < next_free) begin
        check("busy_ready", 64'(req_ready), 64'd0);
        check("busy_p_valid", 64'(p_req_valid), 64'd0);
      end else begin
        check("p_valid_sel", 64'(p_req_valid), (idx < 0) ? 64'd0 : (64'd1 << idx));
      end
      if (req_ready) begin
        acc = 1'b1;
        a   = cyc;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no accept for addr 0x%0h, required accept within 80 cycles", addr);
      req_valid = 1'b0;
      return;
    end
    if (idx >= 0) check("p_req_addr", 64'(p_req_addr), 64'(addr - BASES[idx]));
    check("p_passthru", 64'({p_req_we, p_req_be, p_req_wdata}), 64'({we, req_be, req_wdata}));
    if (idx < 0) begin
      it.due = a + 1;  it.err = 1'b1;  it.rdata = '0;
      next_free = a + 2;
      hold_until = a + 1;
    end else if (lat != 0 && lat <= T) begin
      it.due = a + lat + 1;  it.err = err;  it.rdata = we ? 32'h0 : data;
      next_free = it.due;
      hold_until = a + 1;
    end else begin
      if (exp_tcnt != 16'hFFFF) exp_tcnt++;
      it.due = a + T + 1;  it.err = 1'b1;  it.rdata = '0;
      next_free = it.due;
      hold_until = (lat == 0) ? it.due : a + lat + 1;
    end
    it.tcnt = exp_tcnt;
    if (idx >= 0) begin
      r_idx   = idx;
      r_cycle = (lat == 0) ? -1 : a + lat;
      r_data  = data;
      r_err   = err;
    end
    exp_q.push_back(it);
    last_a = a;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_timeout_cnt"}, 64'(timeout_cnt), 64'd0);
    check({tag, "_p_req_valid"}, 64'(p_req_valid), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  initial begin
    int          k;
    int          w;
    int          m;
    int          lat;
    logic [31:0] addr;
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h1000_0010;
    req_we    = 1'b0;
    req_be    = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    next_free  = cyc;
    hold_until = cyc;

    do_txn(32'h1000_0010, 1'b0, 1, 32'hDEAD_BEEF, 1'b0);
    do_txn(32'h2000_0000, 1'b0, 1, 32'h1111_1111, 1'b0);
    do_txn(32'h4000_0010, 1'b0, 1, 32'h2222_2222, 1'b0);
    do_txn(32'h1000_0100, 1'b0, T + 3, 32'h3333_3333, 1'b0);
    do_txn(32'h1000_0200, 1'b0, 0, 32'h0, 1'b0);
    do_txn(32'h1000_0FFF, 1'b0, 2, 32'h4444_4444, 1'b0);
    do_txn(32'h1000_1000, 1'b0, 2, 32'h5555_5555, 1'b0);
    do_txn(32'h3000_00A0, 1'b0, 1, 32'h6666_6666, 1'b0);
    do_txn(32'h3000_0100, 1'b0, 3, 32'h7777_7777, 1'b1);
    do_txn(32'h1000_0020, 1'b0, T, 32'h8888_8888, 1'b0);
    do_txn(32'h3000_0004, 1'b1, 1, 32'h9999_9999, 1'b1);
    do_txn(32'h3000_0008, 1'b1, 2, 32'hAAAA_AAAA, 1'b0);

    // Reset while the router waits on a silent peripheral; that transaction must vanish.
    do_txn(32'h1000_0040, 1'b0, 0, 32'h0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    void'(exp_q.pop_back());
    r_cycle   = -1;
    exp_tcnt  = '0;
    req_valid = 1'b1;
    req_addr  = 32'h1000_0010;
    rst_n     = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("midrst2");
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    next_free  = cyc;
    hold_until = cyc;
    do_txn(32'h1000_0010, 1'b0, 2, 32'hCAFE_F00D, 1'b0);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      w = $urandom_range(0, NP - 1);
      case (k)
        0, 1, 2, 3: addr = BASES[w] + ($urandom % (RANGES[w] + 32'd1));
        4:          addr = BASES[w] + RANGES[w];
        5:          addr = BASES[w] + RANGES[w] + 32'd1;
        6:          addr = BASES[w] - 32'd1;
        7:          addr = BASES[w];
        default:    addr = $urandom;
      endcase
      m = $urandom_range(0, 9);
      if (m < 7)       lat = $urandom_range(1, 4);
      else if (m == 7) lat = $urandom_range(T - 1, T);
      else if (m == 8) lat = $urandom_range(T + 1, T + 3);
      else             lat = 0;
      do_txn(addr, 1'($urandom), lat, $urandom, ($urandom_range(0, 3) == 0));
    end

    for (int d = 0; d < 100 && exp_q.size() != 0; d++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish before 2000000 time units");
    $fatal(1);
  end

endmodule
